// File: rtl/bht_table_if.sv
// BHT bus: update port from the branch unit, read port from fetch, and
// table status back to both.
interface bht_table_if #(
  parameter int unsigned IDX_W = 9
) ();
  logic             bht_flush;
  logic             bht_write_enable;
  logic [IDX_W-1:0] bht_write_index;
  logic [1:0]       bht_write_counter_select;
  logic             bht_write_inc;
  logic             bht_write_dec;
  logic             bht_valid_in;
  logic             bht_read_enable;
  logic [IDX_W-1:0] bht_read_index;
  logic [7:0]       bht_read_data;
  logic             bht_read_set_valid;
  logic             bht_read_data_valid;
  logic             bht_init_done;

  modport master (
    output bht_flush, bht_write_enable, bht_write_index, bht_write_counter_select,
           bht_write_inc, bht_write_dec, bht_valid_in, bht_read_enable, bht_read_index,
    input  bht_read_data, bht_read_set_valid, bht_read_data_valid, bht_init_done
  );

  modport slave (
    input  bht_flush, bht_write_enable, bht_write_index, bht_write_counter_select,
           bht_write_inc, bht_write_dec, bht_valid_in, bht_read_enable, bht_read_index,
    output bht_read_data, bht_read_set_valid, bht_read_data_valid, bht_init_done
  );
endinterface

// File: rtl/bht_table.sv
// Branch history table: SETS sets of four 2-bit saturating counters plus a
// per-set valid bit. Updates go through a one-entry registered pipeline;
// storage is cleared by a sweep so it can be mapped onto an SRAM.
module bht_table #(
  parameter int unsigned SETS               = 512,
  parameter int unsigned BHTBTB_INDEX_WIDTH = 9,
  parameter logic [1:0]  INIT_CNT           = 2'b01
) (
  input  logic        clock,
  input  logic        reset_n,
  bht_table_if.slave  bus
);

  localparam logic [BHTBTB_INDEX_WIDTH-1:0] IDX_LAST = BHTBTB_INDEX_WIDTH'(SETS - 1);
  localparam logic [BHTBTB_INDEX_WIDTH-1:0] IDX_ONE  = BHTBTB_INDEX_WIDTH'(1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                        state, state_next;
  logic [BHTBTB_INDEX_WIDTH-1:0] init_idx, init_idx_next;
  logic                          init_done_q, init_done_next;

  logic [7:0] cnt_mem   [SETS];
  logic       valid_mem [SETS];

  logic                          u_vld;
  logic [BHTBTB_INDEX_WIDTH-1:0] u_idx;
  logic [1:0]                    u_sel;
  logic                          u_inc, u_dec, u_vin;

  logic                          mem_we;
  logic [BHTBTB_INDEX_WIDTH-1:0] mem_addr;
  logic [7:0]                    mem_wdata;
  logic                          mem_wvalid;

  logic [7:0] rd_set;
  logic       rd_sv;
  logic [7:0] rd_data_q;
  logic       rd_sv_q, rd_dv_q;

  function automatic logic [7:0] apply_upd(input logic [7:0] set, input logic [1:0] sel,
                                           input logic inc, input logic dec);
    logic [7:0] r;
    logic [1:0] c;
    r = set;
    c = set[{sel, 1'b0} +: 2];
    if (inc && !dec && c != 2'b11) c = c + 2'd1;
    else if (dec && !inc && c != 2'b00) c = c - 2'd1;
    r[{sel, 1'b0} +: 2] = c;
    return r;
  endfunction

  // State, sweep index and init_done registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_INIT;
      init_idx    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_next;
      init_idx    <= init_idx_next;
      init_done_q <= init_done_next;
    end
  end

  // Next-state: sweep all sets once, flush restarts the sweep from set 0
  always_comb begin
    state_next    = state;
    init_idx_next = init_idx;
    unique case (state)
      S_INIT: begin
        if (bus.bht_flush) begin
          init_idx_next = '0;
        end else if (init_idx == IDX_LAST) begin
          state_next    = S_READY;
          init_idx_next = '0;
        end else begin
          init_idx_next = init_idx + IDX_ONE;
        end
      end
      S_READY: begin
        if (bus.bht_flush) begin
          state_next    = S_INIT;
          init_idx_next = '0;
        end
      end
      default: state_next = S_INIT;
    endcase
    init_done_next = (state_next == S_READY);
  end

  // Update register: only requests seen in READY are captured
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      u_vld <= 1'b0;
      u_idx <= '0;
      u_sel <= '0;
      u_inc <= 1'b0;
      u_dec <= 1'b0;
      u_vin <= 1'b0;
    end else begin
      u_vld <= (state == S_READY) && bus.bht_write_enable;
      u_idx <= bus.bht_write_index;
      u_sel <= bus.bht_write_counter_select;
      u_inc <= bus.bht_write_inc;
      u_dec <= bus.bht_write_dec;
      u_vin <= bus.bht_valid_in;
    end
  end

  // Single write port: sweep in INIT, held update in READY (a held update
  // is discarded once the table re-enters INIT)
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = init_idx;
    mem_wdata  = {4{INIT_CNT}};
    mem_wvalid = 1'b0;
    if (state == S_INIT) begin
      mem_we = 1'b1;
    end else if (u_vld) begin
      mem_we     = 1'b1;
      mem_addr   = u_idx;
      mem_wdata  = apply_upd(cnt_mem[u_idx], u_sel, u_inc, u_dec);
      mem_wvalid = valid_mem[u_idx] | u_vin;
    end
  end

  // Storage array
  always_ff @(posedge clock) begin
    if (mem_we) begin
      cnt_mem[mem_addr]   <= mem_wdata;
      valid_mem[mem_addr] <= mem_wvalid;
    end
  end

  // Read path: array contents merged with the not-yet-applied update
  always_comb begin
    rd_set = cnt_mem[bus.bht_read_index];
    rd_sv  = valid_mem[bus.bht_read_index];
    if (u_vld && u_idx == bus.bht_read_index) begin
      rd_set = apply_upd(rd_set, u_sel, u_inc, u_dec);
      rd_sv  = rd_sv | u_vin;
    end
  end

  // Read response registers; data holds between reads
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
      rd_sv_q   <= 1'b0;
      rd_dv_q   <= 1'b0;
    end else begin
      rd_dv_q <= 1'b0;
      if (state == S_READY && bus.bht_read_enable) begin
        rd_dv_q   <= 1'b1;
        rd_data_q <= rd_set;
        rd_sv_q   <= rd_sv;
      end
    end
  end

  assign bus.bht_read_data       = rd_data_q;
  assign bus.bht_read_set_valid  = rd_sv_q;
  assign bus.bht_read_data_valid = rd_dv_q;
  assign bus.bht_init_done       = init_done_q;

endmodule

// File: tb/tb_bht_table.sv
// Bench for bht_table: a logical table model (writes take effect for reads
// issued from the next cycle on) checked every cycle, plus directed reads
// against hand-computed values.
module tb_bht_table;
  localparam int SETS = 512;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bht_table_if #(.IDX_W(9)) bus ();

  bht_table #(
    .SETS(512),
    .BHTBTB_INDEX_WIDTH(9),
    .INIT_CNT(2'b01)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Logical model of the table
  logic [1:0] m_cnt [SETS][4];
  logic       m_val [SETS];
  logic       m_ready = 1'b0;
  int         m_icnt  = 0;
  logic [7:0] e_data  = '0;
  logic       e_sv    = 1'b0;
  logic       e_dv    = 1'b0;
  logic       e_done  = 1'b0;

  function automatic logic [1:0] sat(input logic [1:0] c, input logic inc, input logic dec);
    int v;
    v = int'(c);
    if (inc && !dec) v = (v + 1 > 3) ? 3 : v + 1;
    else if (dec && !inc) v = (v - 1 < 0) ? 0 : v - 1;
    return v[1:0];
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b0;
      m_icnt  <= 0;
      e_data  <= '0;
      e_sv    <= 1'b0;
      e_dv    <= 1'b0;
      e_done  <= 1'b0;
      for (int i = 0; i < SETS; i++) begin
        m_val[i] <= 1'b0;
        for (int j = 0; j < 4; j++) m_cnt[i][j] <= 2'b01;
      end
    end else begin
      e_dv <= 1'b0;
      if (m_ready) begin
        if (bus.bht_read_enable) begin
          e_dv   <= 1'b1;
          e_data <= {m_cnt[bus.bht_read_index][3], m_cnt[bus.bht_read_index][2],
                     m_cnt[bus.bht_read_index][1], m_cnt[bus.bht_read_index][0]};
          e_sv   <= m_val[bus.bht_read_index];
        end
        if (bus.bht_write_enable) begin
          m_cnt[bus.bht_write_index][bus.bht_write_counter_select] <=
            sat(m_cnt[bus.bht_write_index][bus.bht_write_counter_select],
                bus.bht_write_inc, bus.bht_write_dec);
          if (bus.bht_valid_in) m_val[bus.bht_write_index] <= 1'b1;
        end
        if (bus.bht_flush) begin
          m_ready <= 1'b0;
          m_icnt  <= 0;
          e_done  <= 1'b0;
          for (int i = 0; i < SETS; i++) begin
            m_val[i] <= 1'b0;
            for (int j = 0; j < 4; j++) m_cnt[i][j] <= 2'b01;
          end
        end else begin
          e_done <= 1'b1;
        end
      end else begin
        if (bus.bht_flush) begin
          m_icnt <= 0;
        end else if (m_icnt == SETS - 1) begin
          m_ready <= 1'b1;
          e_done  <= 1'b1;
          m_icnt  <= 0;
        end else begin
          m_icnt <= m_icnt + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clock) begin
    #1;
    chk("init_done", 32'(bus.bht_init_done), 32'(e_done));
    chk("data_valid", 32'(bus.bht_read_data_valid), 32'(e_dv));
    chk("read_data", 32'(bus.bht_read_data), 32'(e_data));
    chk("set_valid", 32'(bus.bht_read_set_valid), 32'(e_sv));
  end

  task automatic wr(input logic [8:0] idx, input logic [1:0] sel, input logic inc,
                    input logic dec, input logic vin);
    bus.bht_write_enable         = 1'b1;
    bus.bht_write_index          = idx;
    bus.bht_write_counter_select = sel;
    bus.bht_write_inc            = inc;
    bus.bht_write_dec            = dec;
    bus.bht_valid_in             = vin;
    @(negedge clock);
    bus.bht_write_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rd_chk(input logic [8:0] idx, input logic [7:0] exp_d, input logic exp_sv,
                        input string name);
    bus.bht_read_enable = 1'b1;
    bus.bht_read_index  = idx;
    @(posedge clock);
    #1;
    chk({name, "_dv"}, 32'(bus.bht_read_data_valid), 32'd1);
    chk({name, "_data"}, 32'(bus.bht_read_data), 32'(exp_d));
    chk({name, "_sv"}, 32'(bus.bht_read_set_valid), 32'(exp_sv));
    @(negedge clock);
    bus.bht_read_enable = 1'b0;
  endtask

  // Counts clock edges until init_done, bounded
  task automatic wait_init(input string name, input int exp_n);
    int n;
    n = 0;
    while (n < 1000 && bus.bht_init_done !== 1'b1) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(name, 32'(n), 32'(exp_n));
    @(negedge clock);
  endtask

  initial begin
    bus.bht_flush                = 1'b0;
    bus.bht_write_enable         = 1'b0;
    bus.bht_write_index          = '0;
    bus.bht_write_counter_select = '0;
    bus.bht_write_inc            = 1'b0;
    bus.bht_write_dec            = 1'b0;
    bus.bht_valid_in             = 1'b0;
    bus.bht_read_enable          = 1'b0;
    bus.bht_read_index           = '0;

    idle(2);
    chk("rst_init_done", 32'(bus.bht_init_done), 32'd0);
    chk("rst_dv", 32'(bus.bht_read_data_valid), 32'd0);
    chk("rst_data", 32'(bus.bht_read_data), 32'd0);
    chk("rst_sv", 32'(bus.bht_read_set_valid), 32'd0);

    // Release reset with a read of set 0 pending during the sweep
    reset_n             = 1'b1;
    bus.bht_read_enable = 1'b1;
    bus.bht_read_index  = 9'd0;
    @(posedge clock);
    #1;
    chk("init_read_no_dv", 32'(bus.bht_read_data_valid), 32'd0);
    @(negedge clock);
    bus.bht_read_enable = 1'b0;
    wait_init("init_cycles_reset", 511);
    rd_chk(9'd0, 8'h55, 1'b0, "set0_after_init");

    // cnt2 of set 5 saturates at 11
    wr(9'd5, 2'd2, 1'b1, 1'b0, 1'b1);
    wr(9'd5, 2'd2, 1'b1, 1'b0, 1'b1);
    wr(9'd5, 2'd2, 1'b1, 1'b0, 1'b1);
    idle(1);
    rd_chk(9'd5, 8'h75, 1'b1, "inc_sat");

    // cnt0 of set 7 saturates at 00; valid_in 0 still updates the counter
    wr(9'd7, 2'd0, 1'b0, 1'b1, 1'b0);
    wr(9'd7, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(1);
    rd_chk(9'd7, 8'h54, 1'b0, "dec_sat");
    wr(9'd7, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(1);
    rd_chk(9'd7, 8'h54, 1'b0, "dec_sat_again");

    // Same-cycle write invisible, next-cycle read bypasses the update register
    bus.bht_read_enable          = 1'b1;
    bus.bht_read_index           = 9'd9;
    bus.bht_write_enable         = 1'b1;
    bus.bht_write_index          = 9'd9;
    bus.bht_write_counter_select = 2'd1;
    bus.bht_write_inc            = 1'b1;
    bus.bht_write_dec            = 1'b0;
    bus.bht_valid_in             = 1'b0;
    @(posedge clock);
    #1;
    chk("same_cycle_data", 32'(bus.bht_read_data), 32'h55);
    @(negedge clock);
    bus.bht_write_enable = 1'b0;
    @(posedge clock);
    #1;
    chk("bypass_dv", 32'(bus.bht_read_data_valid), 32'd1);
    chk("bypass_data", 32'(bus.bht_read_data), 32'h59);
    @(negedge clock);
    bus.bht_read_enable = 1'b0;

    // inc and dec together: counter unchanged, valid set
    wr(9'd3, 2'd0, 1'b1, 1'b1, 1'b1);
    idle(1);
    rd_chk(9'd3, 8'h55, 1'b1, "inc_dec_both");

    // Flush: full resweep, writes during INIT dropped
    bus.bht_flush = 1'b1;
    @(negedge clock);
    bus.bht_flush = 1'b0;
    wr(9'd5, 2'd2, 1'b1, 1'b0, 1'b1);
    wr(9'd5, 2'd2, 1'b1, 1'b0, 1'b1);
    wait_init("init_cycles_flush", 510);
    rd_chk(9'd5, 8'h55, 1'b0, "flush_set5");
    rd_chk(9'd7, 8'h55, 1'b0, "flush_set7");
    rd_chk(9'd9, 8'h55, 1'b0, "flush_set9");
    rd_chk(9'd3, 8'h55, 1'b0, "flush_set3");

    // Reset in the middle of a sweep restarts it
    wr(9'd9, 2'd1, 1'b1, 1'b0, 1'b1);
    bus.bht_flush = 1'b1;
    @(negedge clock);
    bus.bht_flush = 1'b0;
    idle(100);
    reset_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(bus.bht_read_data), 32'd0);
    chk("async_rst_done", 32'(bus.bht_init_done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wr(9'd9, 2'd1, 1'b1, 1'b0, 1'b1);
    wait_init("init_cycles_midrst", 511);
    rd_chk(9'd9, 8'h55, 1'b0, "midrst_set9");
    rd_chk(9'd5, 8'h55, 1'b0, "midrst_set5");

    // Table updates normally after the resweep
    wr(9'd5, 2'd2, 1'b1, 1'b0, 1'b1);
    idle(1);
    rd_chk(9'd5, 8'h65, 1'b1, "post_rst_inc");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
